// File: rtl/pong_pkg.sv
// Shared types for the pong score keeper: FSM state, winner codes, score type.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  typedef logic [3:0] score_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  // Increment that never passes the match-ending score.
  function automatic score_t sat_inc(input score_t s, input score_t lim);
    return (s < lim) ? score_t'(s + 4'd1) : s;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable 8-bit frame down-counter; advances only on tick, flags zero.
module frame_timer #(
  parameter logic [7:0] RESET_VALUE = 8'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] load_value,
  output logic       zero
);

  logic [7:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= RESET_VALUE;
    end else if (tick) begin
      if (load) begin
        count_reg <= load_value;
      end else if (dec && count_reg != 8'd0) begin
        count_reg <= count_reg - 8'd1;
      end
    end
  end

  assign zero = (count_reg == 8'd0);

endmodule

// File: rtl/score_keeper.sv
// Pong match score keeper: PLAY/HOLD/OVER FSM with registered outputs.
// Define SCORE_KEEPER_AUTO_RESTART_EN to clear the match automatically after OVER times out.
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE      = 9,
  parameter int HOLD_FRAMES    = 30,
  parameter int RESTART_FRAMES = 180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       goal_p1,
  input  logic       goal_p2,
  input  logic       new_match,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       serve_rst,
  output logic       match_over,
  output logic [1:0] winner
);

  localparam score_t     WIN          = score_t'(WIN_SCORE);
  localparam logic [7:0] HOLD_LOAD    = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] RESTART_LOAD = 8'(RESTART_FRAMES - 1);

  state_t     state_reg, state_next;
  score_t     score_p1_reg, score_p1_next;
  score_t     score_p2_reg, score_p2_next;
  logic [1:0] winner_reg, winner_next;
  logic       goal_p1_reg, goal_p2_reg;
  logic       serve_rst_reg, match_over_reg;
  logic       rise_p1, rise_p2;
  logic       timer_load, timer_dec, timer_zero, do_clear;
  logic [7:0] timer_value;

  assign rise_p1 = goal_p1 & ~goal_p1_reg;
  assign rise_p2 = goal_p2 & ~goal_p2_reg;

  always_comb begin
    state_next    = state_reg;
    score_p1_next = score_p1_reg;
    score_p2_next = score_p2_reg;
    winner_next   = winner_reg;
    timer_load    = 1'b0;
    timer_dec     = 1'b0;
    timer_value   = HOLD_LOAD;
    do_clear      = new_match;

    if (!new_match) begin
      case (state_reg)
        ST_PLAY: begin
          if (rise_p1 && rise_p2) begin
            state_next = ST_HOLD;
            timer_load = 1'b1;
          end else if (rise_p1 || rise_p2) begin
            if (rise_p1) score_p1_next = sat_inc(score_p1_reg, WIN);
            else         score_p2_next = sat_inc(score_p2_reg, WIN);
            timer_load = 1'b1;
            if (score_p1_next == WIN || score_p2_next == WIN) begin
              state_next  = ST_OVER;
              winner_next = (score_p1_next == WIN) ? WINNER_P1 : WINNER_P2;
              timer_value = RESTART_LOAD;
            end else begin
              state_next = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (timer_zero) state_next = ST_PLAY;
          else            timer_dec  = 1'b1;
        end
        ST_OVER: begin
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
          if (timer_zero) do_clear  = 1'b1;
          else            timer_dec = 1'b1;
`endif
        end
        default: begin
          state_next = ST_HOLD;
          timer_load = 1'b1;
        end
      endcase
    end

    // A clear (explicit or timed-out restart) overrides anything decided above.
    if (do_clear) begin
      state_next    = ST_HOLD;
      score_p1_next = '0;
      score_p2_next = '0;
      winner_next   = WINNER_NONE;
      timer_load    = 1'b1;
      timer_dec     = 1'b0;
      timer_value   = HOLD_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_HOLD;
      score_p1_reg   <= '0;
      score_p2_reg   <= '0;
      winner_reg     <= WINNER_NONE;
      goal_p1_reg    <= 1'b0;
      goal_p2_reg    <= 1'b0;
      serve_rst_reg  <= 1'b1;
      match_over_reg <= 1'b0;
    end else if (tick) begin
      state_reg      <= state_next;
      score_p1_reg   <= score_p1_next;
      score_p2_reg   <= score_p2_next;
      winner_reg     <= winner_next;
      goal_p1_reg    <= goal_p1;
      goal_p2_reg    <= goal_p2;
      serve_rst_reg  <= (state_next != ST_PLAY);
      match_over_reg <= (state_next == ST_OVER);
    end
  end

  frame_timer #(
    .RESET_VALUE(HOLD_LOAD)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .load      (timer_load),
    .dec       (timer_dec),
    .load_value(timer_value),
    .zero      (timer_zero)
  );

  assign score_p1   = score_p1_reg;
  assign score_p2   = score_p2_reg;
  assign serve_rst  = serve_rst_reg;
  assign match_over = match_over_reg;
  assign winner     = winner_reg;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed vector table, match-win sequence, async reset, random vs model.
module tb_score_keeper;

  localparam int WIN     = 9;
  localparam int HOLD    = 30;
  localparam int RESTART = 180;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       goal_p1 = 1'b0;
  logic       goal_p2 = 1'b0;
  logic       new_match = 1'b0;
  logic [3:0] score_p1, score_p2;
  logic       serve_rst, match_over;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_keeper dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .goal_p1(goal_p1), .goal_p2(goal_p2), .new_match(new_match),
    .score_p1(score_p1), .score_p2(score_p2),
    .serve_rst(serve_rst), .match_over(match_over), .winner(winner)
  );

  // Reference model: phase 0=play 1=hold 2=over; left = ticks remaining in the phase.
  int m_s1, m_s2, m_w, m_phase, m_left;
  bit m_g1, m_g2;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_w = 0; m_phase = 1; m_left = HOLD; m_g1 = 0; m_g2 = 0;
  endtask

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_w = 0; m_phase = 1; m_left = HOLD;
  endtask

  task automatic model_tick(input bit g1, input bit g2, input bit nm);
    bit e1, e2;
    e1 = g1 && !m_g1;
    e2 = g2 && !m_g2;
    m_g1 = g1;
    m_g2 = g2;
    if (nm) begin
      model_clear();
    end else if (m_phase == 0) begin
      if (e1 || e2) begin
        m_phase = 1;
        m_left  = HOLD;
        if (!(e1 && e2)) begin
          if (e1) m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1;
          else    m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1;
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_phase = 2;
            m_left  = RESTART;
            m_w     = (m_s1 == WIN) ? 1 : 2;
          end
        end
      end
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) m_phase = 0;
    end else begin
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
      m_left--;
      if (m_left == 0) model_clear();
`endif
    end
  endtask

  task automatic check(input string name, input int s1, input int s2,
                       input int sr, input int mo, input int w);
    checks++;
    if (int'(score_p1) != s1 || int'(score_p2) != s2 || int'(serve_rst) != sr ||
        int'(match_over) != mo || int'(winner) != w) begin
      errors++;
      $display("FAIL %s: got s1=%0d s2=%0d serve=%0d over=%0d win=%0d, required s1=%0d s2=%0d serve=%0d over=%0d win=%0d",
               name, score_p1, score_p2, serve_rst, match_over, winner, s1, s2, sr, mo, w);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_s1, m_s2, (m_phase != 0) ? 1 : 0, (m_phase == 2) ? 1 : 0, m_w);
  endtask

  // Drive at negedge, let the posedge act, return at next negedge.
  task automatic do_cycle(input bit t, input bit g1, input bit g2, input bit nm);
    tick = t; goal_p1 = g1; goal_p2 = g2; new_match = nm;
    @(posedge clk);
    if (t && rst_n) model_tick(g1, g2, nm);
    @(negedge clk);
  endtask

  task automatic do_ticks(input int n, input bit g1, input bit g2, input bit nm);
    for (int i = 0; i < n; i++) begin
      do_cycle(1'b1, g1, g2, nm);
      do_cycle(1'b0, g1, g2, nm);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit g1; bit g2; bit nm; int n;
    int s1; int s2; int sr; int mo; int w;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{0, 0, 0, 29,  0, 0, 1, 0, 0};  // still held one tick before release
    vecs[1]  = '{0, 0, 0, 1,   0, 0, 0, 0, 0};  // released on tick 30
    vecs[2]  = '{1, 0, 0, 1,   1, 0, 1, 0, 0};  // p1 scores
    vecs[3]  = '{1, 0, 0, 30,  1, 0, 0, 0, 0};  // held level: no second point
    vecs[4]  = '{0, 1, 0, 1,   1, 1, 1, 0, 0};
    vecs[5]  = '{0, 1, 0, 100, 1, 1, 0, 0, 0};  // p2 held 100 ticks
    vecs[6]  = '{0, 0, 0, 1,   1, 1, 0, 0, 0};
    vecs[7]  = '{1, 1, 0, 1,   1, 1, 1, 0, 0};  // simultaneous: no score, hold
    vecs[8]  = '{0, 0, 0, 29,  1, 1, 1, 0, 0};
    vecs[9]  = '{0, 0, 0, 1,   1, 1, 0, 0, 0};
    vecs[10] = '{1, 0, 0, 1,   2, 1, 1, 0, 0};
    vecs[11] = '{0, 0, 0, 30,  2, 1, 0, 0, 0};
    vecs[12] = '{1, 0, 0, 1,   3, 1, 1, 0, 0};
    vecs[13] = '{0, 0, 0, 30,  3, 1, 0, 0, 0};
    vecs[14] = '{0, 1, 0, 1,   3, 2, 1, 0, 0};
    vecs[15] = '{0, 0, 0, 5,   3, 2, 1, 0, 0};
    vecs[16] = '{0, 0, 1, 1,   0, 0, 1, 0, 0};  // new_match mid-hold
    vecs[17] = '{0, 0, 0, 29,  0, 0, 1, 0, 0};  // hold reloaded to full length
    vecs[18] = '{0, 0, 0, 1,   0, 0, 0, 0, 0};

    model_reset();
    repeat (2) @(negedge clk);
    check("reset", 0, 0, 1, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release_no_tick", 0, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      do_ticks(vecs[i].n, vecs[i].g1, vecs[i].g2, vecs[i].nm);
      check($sformatf("vec%0d", i), vecs[i].s1, vecs[i].s2, vecs[i].sr, vecs[i].mo, vecs[i].w);
    end

    // Async reset mid-hold, asserted between clock edges.
    do_ticks(1, 0, 1, 0);
    do_ticks(3, 0, 0, 0);
    check("pre_async_reset", 0, 1, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 0, 0, 1, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Drive p1 to the winning score.
    do_ticks(HOLD, 0, 0, 0);
    for (int k = 1; k <= WIN; k++) begin
      do_ticks(1, 1, 0, 0);
      if (k < WIN) do_ticks(HOLD, 0, 0, 0);
    end
    check("win_p1", 9, 0, 1, 1, 1);
    for (int k = 0; k < 5; k++) begin
      do_ticks(1, 0, 0, 0);
      do_ticks(1, 1, 1, 0);
    end
    check("over_ignores_goals", 9, 0, 1, 1, 1);
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
    do_ticks(RESTART - 11, 0, 0, 0);
    check("over_before_restart", 9, 0, 1, 1, 1);
    do_ticks(1, 0, 0, 0);
    check("auto_restart", 0, 0, 1, 0, 0);
`else
    do_ticks(1000, 0, 0, 0);
    check("over_persists", 9, 0, 1, 1, 1);
`endif
    do_ticks(1, 0, 0, 1);
    check("new_match_from_over", 0, 0, 1, 0, 0);
    check_model("model_sync");

    // Randomized play against the reference model.
    pulse_reset();
    begin
      bit g1, g2;
      g1 = 0; g2 = 0;
      for (int c = 0; c < 6000; c++) begin
        if ($urandom_range(0, 5) == 0) g1 = ~g1;
        if ($urandom_range(0, 5) == 0) g2 = ~g2;
        do_cycle($urandom_range(0, 2) != 0, g1, g2, $urandom_range(0, 399) == 0);
        check_model("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
